// File: rtl/pc_stack_unit.sv
// Program counter with circular return stack, skip/goto/call/ret and an interrupt vector.
// All state advances on clk edges qualified by adv; the sticky flags are cleared independently of adv.
module pc_stack_unit #(
   parameter int PC_W      = 8,
   parameter int DEPTH     = 8,
   parameter int RESET_VEC = 0,
   parameter int IRQ_VEC   = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     adv,
   input  logic [2:0]               op,
   input  logic [PC_W-1:0]          target,
   input  logic                     irq,
   input  logic                     gie_set,
   input  logic                     flag_clr,
   output logic [PC_W-1:0]          pc,
   output logic [$clog2(DEPTH):0]   depth,
   output logic                     gie,
   output logic                     irq_ack,
   output logic                     ovf,
   output logic                     unf
);

   localparam int AW = $clog2(DEPTH);
   localparam int DW = AW + 1;

   localparam logic [2:0] OP_INC  = 3'b000;
   localparam logic [2:0] OP_SKIP = 3'b001;
   localparam logic [2:0] OP_GOTO = 3'b010;
   localparam logic [2:0] OP_CALL = 3'b011;
   localparam logic [2:0] OP_RET  = 3'b100;
   localparam logic [2:0] OP_RETI = 3'b101;

   localparam logic [PC_W-1:0] RST_PC = PC_W'(RESET_VEC);
   localparam logic [PC_W-1:0] IRQ_PC = PC_W'(IRQ_VEC);
   localparam logic [DW-1:0]   FULL   = DW'(DEPTH);

   logic [PC_W-1:0] mem [DEPTH];

   logic [PC_W-1:0] pc_q, pc_d;
   logic [AW-1:0]   sp_q, sp_d;
   logic [DW-1:0]   depth_q, depth_d;
   logic            gie_q, gie_d;
   logic            ack_q, ack_d;
   logic            ovf_q, ovf_d;
   logic            unf_q, unf_d;

   logic            push, pop;
   logic [PC_W-1:0] push_val;
   logic [AW-1:0]   sp_top;
   logic            ovf_set, unf_set;

   assign sp_top = sp_q - AW'(1);

   always_comb begin
      pc_d     = pc_q;
      sp_d     = sp_q;
      depth_d  = depth_q;
      gie_d    = gie_q;
      ack_d    = 1'b0;
      push     = 1'b0;
      pop      = 1'b0;
      push_val = pc_q + PC_W'(1);
      ovf_set  = 1'b0;
      unf_set  = 1'b0;

      if (adv) begin
         // An interrupt replaces the current op, saving pc so the op is refetched.
         if (irq && gie_q) begin
            push     = 1'b1;
            push_val = pc_q;
            pc_d     = IRQ_PC;
            gie_d    = 1'b0;
            ack_d    = 1'b1;
         end else begin
            if (gie_set) gie_d = 1'b1;
            case (op)
               OP_INC:  pc_d = pc_q + PC_W'(1);
               OP_SKIP: pc_d = pc_q + PC_W'(2);
               OP_GOTO: pc_d = target;
               OP_CALL: begin
                  push = 1'b1;
                  pc_d = target;
               end
               OP_RET:  pop = 1'b1;
               OP_RETI: begin
                  pop   = 1'b1;
                  gie_d = 1'b1;
               end
               default: ;
            endcase
         end
      end

      if (push) begin
         sp_d = sp_q + AW'(1);
         if (depth_q == FULL) ovf_set = 1'b1;
         else depth_d = depth_q + DW'(1);
      end

      if (pop) begin
         if (depth_q == '0) begin
            pc_d    = RST_PC;
            unf_set = 1'b1;
         end else begin
            pc_d    = mem[sp_top];
            sp_d    = sp_top;
            depth_d = depth_q - DW'(1);
         end
      end

      ovf_d = ovf_set | (ovf_q & ~flag_clr);
      unf_d = unf_set | (unf_q & ~flag_clr);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_q    <= RST_PC;
         sp_q    <= '0;
         depth_q <= '0;
         gie_q   <= 1'b0;
         ack_q   <= 1'b0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         pc_q    <= pc_d;
         sp_q    <= sp_d;
         depth_q <= depth_d;
         gie_q   <= gie_d;
         ack_q   <= ack_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[sp_q] <= push_val;
   end

   assign pc      = pc_q;
   assign depth   = depth_q;
   assign gie     = gie_q;
   assign irq_ack = ack_q;
   assign ovf     = ovf_q;
   assign unf     = unf_q;

endmodule

// File: tb/tb_pc_stack_unit.sv
// Directed bench for pc_stack_unit with default parameters (PC_W=8, DEPTH=8).
// Expected values are hand-computed constants checked by immediate assertions.
module tb_pc_stack_unit;

   logic       clk;
   logic       reset;
   logic       adv;
   logic [2:0] op;
   logic [7:0] target;
   logic       irq;
   logic       gie_set;
   logic       flag_clr;
   logic [7:0] pc;
   logic [3:0] depth;
   logic       gie;
   logic       irq_ack;
   logic       ovf;
   logic       unf;

   int checks = 0;
   int errors = 0;

   localparam logic [2:0] INC  = 3'b000;
   localparam logic [2:0] SKIP = 3'b001;
   localparam logic [2:0] GOTO = 3'b010;
   localparam logic [2:0] CALL = 3'b011;
   localparam logic [2:0] RET  = 3'b100;
   localparam logic [2:0] RETI = 3'b101;
   localparam logic [2:0] HOLD = 3'b110;

   pc_stack_unit #(
      .PC_W(8), .DEPTH(8), .RESET_VEC(0), .IRQ_VEC(4)
   ) dut (
      .clk(clk), .reset(reset), .adv(adv), .op(op), .target(target),
      .irq(irq), .gie_set(gie_set), .flag_clr(flag_clr),
      .pc(pc), .depth(depth), .gie(gie), .irq_ack(irq_ack),
      .ovf(ovf), .unf(unf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic a, input logic [2:0] o, input logic [7:0] t,
                       input logic i, input logic g, input logic f);
      adv = a; op = o; target = t; irq = i; gie_set = g; flag_clr = f;
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b0; adv = 0; op = HOLD; target = 0;
      irq = 0; gie_set = 0; flag_clr = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_pc", 16'(pc), 16'h00);
      chk("rst_depth", 16'(depth), 16'd0);
      chk("rst_gie", 16'(gie), 16'd0);
      chk("rst_ack", 16'(irq_ack), 16'd0);
      chk("rst_ovf", 16'(ovf), 16'd0);
      chk("rst_unf", 16'(unf), 16'd0);
      @(negedge clk);
      reset = 1'b1;

      for (int k = 1; k <= 5; k++) begin
         step(1, INC, 8'h00, 0, 0, 0);
         chk("inc_pc", 16'(pc), 16'(k));
      end

      // rebuild some state then reset asynchronously mid-cycle at pc=3
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("rst2_pc", 16'(pc), 16'h00);
      @(negedge clk);
      reset = 1'b1;
      step(1, INC, 8'h00, 0, 0, 0);
      step(1, INC, 8'h00, 0, 0, 0);
      step(1, CALL, 8'h03, 0, 1, 0);
      chk("pre_pc", 16'(pc), 16'h03);
      chk("pre_depth", 16'(depth), 16'd1);
      chk("pre_gie", 16'(gie), 16'd1);
      #2 reset = 1'b0;
      #1;
      chk("amid_pc", 16'(pc), 16'h00);
      chk("amid_depth", 16'(depth), 16'd0);
      chk("amid_gie", 16'(gie), 16'd0);
      #1 reset = 1'b1;

      step(1, GOTO, 8'h10, 0, 0, 0);
      chk("goto_pc", 16'(pc), 16'h10);
      step(1, CALL, 8'h40, 0, 0, 0);
      chk("call1_pc", 16'(pc), 16'h40);
      chk("call1_d", 16'(depth), 16'd1);
      step(1, CALL, 8'h80, 0, 0, 0);
      chk("call2_pc", 16'(pc), 16'h80);
      chk("call2_d", 16'(depth), 16'd2);
      step(1, RET, 8'h00, 0, 0, 0);
      chk("ret1_pc", 16'(pc), 16'h41);
      chk("ret1_d", 16'(depth), 16'd1);
      step(1, RET, 8'h00, 0, 0, 0);
      chk("ret2_pc", 16'(pc), 16'h11);
      chk("ret2_d", 16'(depth), 16'd0);

      step(1, GOTO, 8'h00, 0, 0, 0);
      for (int k = 1; k <= 9; k++) begin
         step(1, CALL, 8'(k * 16), 0, 0, 0);
         chk("ovf_pc", 16'(pc), 16'(k * 16));
         chk("ovf_flag", 16'(ovf), (k == 9) ? 16'd1 : 16'd0);
      end
      chk("ovf_depth", 16'(depth), 16'd8);
      for (int k = 8; k >= 1; k--) begin
         step(1, RET, 8'h00, 0, 0, 0);
         chk("pop_pc", 16'(pc), 16'(k * 16 + 1));
         chk("pop_d", 16'(depth), 16'(k - 1));
      end
      step(1, RET, 8'h00, 0, 0, 0);
      chk("unf_pc", 16'(pc), 16'h00);
      chk("unf_flag", 16'(unf), 16'd1);
      chk("unf_d", 16'(depth), 16'd0);
      chk("unf_ovf", 16'(ovf), 16'd1);
      step(0, HOLD, 8'h00, 0, 0, 1);
      chk("clr_ovf", 16'(ovf), 16'd0);
      chk("clr_unf", 16'(unf), 16'd0);
      chk("clr_pc", 16'(pc), 16'h00);

      step(1, GOTO, 8'h20, 0, 1, 0);
      chk("gie_pc", 16'(pc), 16'h20);
      chk("gie_on", 16'(gie), 16'd1);
      step(1, GOTO, 8'h55, 1, 1, 0);
      chk("irq_pc", 16'(pc), 16'h04);
      chk("irq_ack", 16'(irq_ack), 16'd1);
      chk("irq_gie", 16'(gie), 16'd0);
      chk("irq_d", 16'(depth), 16'd1);
      step(1, RETI, 8'h00, 1, 0, 0);
      chk("reti_pc", 16'(pc), 16'h20);
      chk("reti_gie", 16'(gie), 16'd1);
      chk("reti_ack", 16'(irq_ack), 16'd0);
      chk("reti_d", 16'(depth), 16'd0);

      step(1, GOTO, 8'hFF, 0, 0, 0);
      step(1, SKIP, 8'h00, 0, 0, 0);
      chk("skip_wrap", 16'(pc), 16'h01);
      step(1, INC, 8'h00, 0, 0, 0);
      chk("inc_after", 16'(pc), 16'h02);
      step(0, GOTO, 8'h77, 1, 0, 0);
      chk("hold_pc", 16'(pc), 16'h02);
      chk("hold_ack", 16'(irq_ack), 16'd0);
      chk("hold_d", 16'(depth), 16'd0);

      for (int k = 0; k < 8; k++) step(1, CALL, 8'h30, 0, 0, 0);
      chk("fill_d", 16'(depth), 16'd8);
      chk("fill_ovf", 16'(ovf), 16'd0);
      step(1, CALL, 8'h30, 0, 0, 1);
      chk("prio_ovf", 16'(ovf), 16'd1);
      chk("prio_d", 16'(depth), 16'd8);
      step(0, HOLD, 8'h00, 0, 0, 1);
      chk("prio_clr", 16'(ovf), 16'd0);
      step(1, RET, 8'h00, 0, 0, 0);
      chk("fill_ret", 16'(pc), 16'h31);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
